// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the control-bundle pipeline: bit positions inside
// the WB / M / EX bundles and the forwarding-select encoding.
package pipe_ctrl_pkg;

  // Bundle widths
  localparam int WB_W    = 2;
  localparam int M_W     = 3;
  localparam int EX_W    = 5;
  localparam int ALUOP_W = 3;

  // WB bundle bit positions
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  // M bundle bit positions
  localparam int M_BRANCH   = 0;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 2;

  // EX bundle bit positions
  localparam int EX_REGDST    = 0;
  localparam int EX_ALUOP_LSB = 1;
  localparam int EX_ALUSRC    = 4;

  // ALU operand source select
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/pipe_ctrl_stager_fwd_select.sv
// Forwarding compare for one ALU operand. The nearer producer (EX/MEM) wins
// over the older one (MEM/WB); register 0 is never forwarded.
module fwd_select
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] i_src_reg,
  input  logic             i_exmem_wr,
  input  logic [REG_W-1:0] i_exmem_dst,
  input  logic             i_memwb_wr,
  input  logic [REG_W-1:0] i_memwb_dst,
  output logic [1:0]       o_fwd_sel
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  assign w_exmem_hit = i_exmem_wr && (i_exmem_dst != '0) && (i_exmem_dst == i_src_reg);
  assign w_memwb_hit = i_memwb_wr && (i_memwb_dst != '0) && (i_memwb_dst == i_src_reg);

  // Priority select: youngest matching producer first, register file last.
  always_comb begin
    // NOTE: every branch of a combinational block must leave the output
    // assigned; the default up front guarantees that and prevents a latch.
    o_fwd_sel = FWD_RF;
    if (w_exmem_hit) begin
      o_fwd_sel = FWD_EXMEM;
    end else if (w_memwb_hit) begin
      o_fwd_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_ctrl_stager.sv
// Carries decoded control bundles through ID/EX, EX/MEM and MEM/WB, detects
// load-use hazards (stall + bubble), flushes on a taken branch, and produces
// operand forwarding selects plus saturating stall/flush event counters.
module pipe_ctrl_stager
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [WB_W-1:0]    id_wb,
  input  logic [M_W-1:0]     id_m,
  input  logic [EX_W-1:0]    id_ex,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   id_rd,
  input  logic               mem_zero,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic [REG_W-1:0]   ex_dst,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_branch,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [REG_W-1:0]   wb_dst,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               stall,
  output logic               flush,
  output logic               pc_src,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef struct packed {
    logic             valid;
    logic [WB_W-1:0]  wb;
    logic [M_W-1:0]   m;
    logic [EX_W-1:0]  ex;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic             valid;
    logic [WB_W-1:0]  wb;
    logic [M_W-1:0]   m;
    logic [REG_W-1:0] dst;
  } exmem_t;

  typedef struct packed {
    logic             valid;
    logic [WB_W-1:0]  wb;
    logic [REG_W-1:0] dst;
  } memwb_t;

  localparam int IDEX_W = $bits(idex_t);

  idex_t            r_idex;
  exmem_t           r_exmem;
  memwb_t           r_memwb;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [IDEX_W-1:0] w_id_raw;
  logic [IDEX_W-1:0] w_id_bits;
  idex_t             w_id_clean;
  idex_t             w_idex_nxt;
  exmem_t            w_exmem_nxt;
  memwb_t            w_memwb_nxt;
  logic [REG_W-1:0]  w_ex_dst;
  logic              w_flush;
  logic              w_load_use;
  logic              w_stall;
  logic              w_exmem_wr;
  logic              w_memwb_wr;

  // Capture the ID bundle with any unknown bit forced to 0 so don't-care
  // fields (RegDst, MemtoReg on stores/branches) cannot leak downstream.
  always_comb begin
    w_id_raw = {id_valid, id_wb, id_m, id_ex, id_rs, id_rt, id_rd};
    for (int i = 0; i < IDEX_W; i++) begin
      w_id_bits[i] = (w_id_raw[i] === 1'b1);
    end
  end

  assign w_id_clean = idex_t'(w_id_bits);

  // Hazard detection: a taken branch in MEM overrides a load-use stall.
  assign w_flush    = r_exmem.valid & r_exmem.m[M_BRANCH] & mem_zero;
  assign w_load_use = r_idex.valid & r_idex.m[M_MEMREAD] & w_id_clean.valid
                    & (r_idex.rt != '0)
                    & ((r_idex.rt == w_id_clean.rs) | (r_idex.rt == w_id_clean.rt));
  assign w_stall    = w_load_use & ~w_flush;

  assign w_ex_dst = r_idex.ex[EX_REGDST] ? r_idex.rd : r_idex.rt;

  // Next-state for the three stage registers, including bubble insertion.
  always_comb begin
    w_idex_nxt = w_id_clean;
    if (w_flush || w_stall) begin
      w_idex_nxt = '0;
    end

    w_exmem_nxt.valid = r_idex.valid;
    w_exmem_nxt.wb    = r_idex.wb;
    w_exmem_nxt.m     = r_idex.m;
    w_exmem_nxt.dst   = w_ex_dst;
    if (w_flush) begin
      w_exmem_nxt = '0;
    end

    w_memwb_nxt.valid = r_exmem.valid;
    w_memwb_nxt.wb    = r_exmem.wb;
    w_memwb_nxt.dst   = r_exmem.dst;
  end

  // Stage registers advance every cycle; bubbles are already folded in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      r_idex  <= w_idex_nxt;
      r_exmem <= w_exmem_nxt;
      r_memwb <= w_memwb_nxt;
    end
  end

  // Saturating event counters: hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign w_exmem_wr = r_exmem.valid & r_exmem.wb[WB_REGWRITE];
  assign w_memwb_wr = r_memwb.valid & r_memwb.wb[WB_REGWRITE];

  fwd_select #(.REG_W(REG_W)) u_fwd_a (
    .i_src_reg  (r_idex.rs),
    .i_exmem_wr (w_exmem_wr),
    .i_exmem_dst(r_exmem.dst),
    .i_memwb_wr (w_memwb_wr),
    .i_memwb_dst(r_memwb.dst),
    .o_fwd_sel  (fwd_a)
  );

  fwd_select #(.REG_W(REG_W)) u_fwd_b (
    .i_src_reg  (r_idex.rt),
    .i_exmem_wr (w_exmem_wr),
    .i_exmem_dst(r_exmem.dst),
    .i_memwb_wr (w_memwb_wr),
    .i_memwb_dst(r_memwb.dst),
    .o_fwd_sel  (fwd_b)
  );

  // EX outputs are raw fields; MEM and WB outputs are qualified by valid.
  assign ex_alu_op     = r_idex.ex[EX_ALUOP_LSB +: ALUOP_W];
  assign ex_alu_src    = r_idex.ex[EX_ALUSRC];
  assign ex_dst        = w_ex_dst;
  assign mem_read      = r_exmem.valid & r_exmem.m[M_MEMREAD];
  assign mem_write     = r_exmem.valid & r_exmem.m[M_MEMWRITE];
  assign mem_branch    = r_exmem.valid & r_exmem.m[M_BRANCH];
  assign wb_reg_write  = r_memwb.valid & r_memwb.wb[WB_REGWRITE];
  assign wb_mem_to_reg = r_memwb.valid & r_memwb.wb[WB_MEMTOREG];
  assign wb_dst        = r_memwb.valid ? r_memwb.dst : '0;
  assign stall         = w_stall;
  assign flush         = w_flush;
  assign pc_src        = w_flush;
  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;

endmodule
